nf10_oq_port_egress_fifo: RTL
=============================

Name: nf10_oq_port_egress_fifo

Overview:
- Store-and-forward packet FIFO for one output-queue port.
- Sits between the BRAM output queue's port-0 master stream and the 10G interface egress. In simulation, the AXIS recorder sits on that egress.
- Releases only complete packets downstream, so the MAC never underruns mid-frame.
- Drops any packet that does not fit and reports the drop.

Parameters:
- C_AXIS_DATA_WIDTH, 256, tdata width; tstrb width is C_AXIS_DATA_WIDTH/8.
- C_AXIS_TUSER_WIDTH, 128, tuser width, carried per beat unchanged.
- C_DEPTH, 64, FIFO entries (beats); power of 2, minimum 4.
- C_CNT_WIDTH, 32, width of statistics counters (used only with the optional feature).

Ports:
- aclk  in  1  clock; all logic rising-edge.
- aresetn  in  1  synchronous, active-low reset.
- s_axis_tdata  in  256  ingress data from output queue.
- s_axis_tstrb  in  32  ingress byte strobes.
- s_axis_tuser  in  128  ingress sideband (length/port metadata).
- s_axis_tvalid  in  1  ingress valid.
- s_axis_tready  out  1  ingress ready.
- s_axis_tlast  in  1  ingress end of packet.
- m_axis_tdata  out  256  egress data.
- m_axis_tstrb  out  32  egress strobes.
- m_axis_tuser  out  128  egress sideband.
- m_axis_tvalid  out  1  egress valid.
- m_axis_tready  in  1  egress ready.
- m_axis_tlast  out  1  egress end of packet.
- pkt_drop  out  1  one-cycle pulse per dropped packet.

Behaviour:
- Reset (aresetn=0 at an edge):
  - All outputs go to 0: tready, m_axis_* and pkt_drop.
  - Pointers, packet count and drop state are cleared.
  - s_axis_tready rises the first cycle after aresetn=1 is sampled.
  - Reset mid-packet discards all contents, including partial and committed packets.
- Storage: C_DEPTH entries of {tlast, tuser, tstrb, tdata}. Written bits are preserved exactly.
- Pointers: wr_ptr, commit_ptr and rd_ptr are each log2(C_DEPTH)+1 bits (wrap bit included).
  - Full: wr_ptr - rd_ptr == C_DEPTH.
  - Empty-committed: commit_ptr == rd_ptr.
- Ingress (drop mode):
  - s_axis_tready=1 whenever out of reset; backpressure is never applied upstream.
  - Accepted beat, not dropping, FIFO not full: write at wr_ptr, then wr_ptr+1.
  - Accepted beat with tlast: commit_ptr <= wr_ptr+1 and pkt_cnt+1.
- Drop state machine, states ACCEPT and DROP:
  - ACCEPT -> DROP: a beat arrives while full and without tlast. wr_ptr rewinds to commit_ptr.
  - A full-arrival beat that carries tlast rewinds wr_ptr and pulses pkt_drop the next cycle; the state stays ACCEPT.
  - In DROP: beats are discarded. The tlast beat pulses pkt_drop the next cycle and returns to ACCEPT.
  - Packets longer than C_DEPTH beats are always dropped. A C_DEPTH-beat packet fits only if the FIFO is empty.
- Egress:
  - m_axis_tvalid=1 iff pkt_cnt>0 and the output register holds a beat from a committed packet.
  - Output register is first-word-fall-through, prefetched from the memory read.
  - Latency: ingress tlast accepted at cycle N gives first egress tvalid at N+2 with an idle FIFO.
  - Back-to-back beats at full throughput while m_axis_tready=1.
  - While tvalid=1 and tready=0, all m_axis_* hold stable.
- pkt_cnt: increments on ingress commit and decrements on the egress tlast handshake. Both in the same cycle leaves it unchanged.
  - Once pkt_cnt reaches 0 the output stops after that packet's tlast. Uncommitted beats are never presented.
- Simultaneous write and read in a full FIFO: the read frees its slot only at the next edge, so the write sees full (conservative).
- tstrb is passed through unchecked; all-zero strobes are legal.

Optional Feature:
- Macro NF10_OQ_EGRESS_STATS_EN.
- Defined: adds outputs stat_pkt_out, stat_pkt_drop and stat_byte_out, each C_CNT_WIDTH bits, cleared by reset.
  - stat_pkt_out increments on each egress tlast handshake.
  - stat_pkt_drop increments with each pkt_drop pulse.
  - stat_byte_out adds popcount(m_axis_tstrb) per egress handshake.
  - All counters wrap modulo 2^C_CNT_WIDTH.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset, then a single 3-beat packet with tuser=0x40 and last tstrb=0x0000FFFF, m_tready=1 -> egress matches bit-for-bit; first tvalid 2 cycles after ingress tlast; pkt_drop never pulses.
- Single 3-beat packet with m_tready held 0 for 10 cycles, then 1 -> tvalid stays 1 with stable data throughout; 3 beats then delivered on consecutive cycles.
- C_DEPTH=64 with m_tready=0: a 60-beat packet followed by an 8-beat packet -> first packet kept, second dropped; exactly one pkt_drop pulse on the cycle after the second packet's tlast; only the 60-beat packet emerges.
- 65-beat packet into an empty FIFO -> dropped, one pkt_drop; the next 2-beat packet passes intact.
- aresetn=0 for one cycle mid-packet with two committed packets buffered -> m_tvalid=0 next cycle, tready=0 during reset; after release a new packet passes and no stale data emerges.
- With NF10_OQ_EGRESS_STATS_EN: 4 packets of 64 bytes each pass and 1 is dropped -> stat_pkt_out=4, stat_pkt_drop=1, stat_byte_out=256.

Source files
------------

// File: rtl/nf10_oq_port_egress_fifo.sv
// ---------------------------------------------------------------------------
// nf10_oq_port_egress_fifo
//
// Store-and-forward packet FIFO for one output-queue port. It sits between
// the BRAM output queue's port-0 master stream and the 10G egress. Only
// complete (committed) packets are released downstream, so the MAC never
// underruns mid-frame. A packet that does not fit is dropped in its entirety
// and reported with a one-cycle pkt_drop pulse. Upstream is never stalled.
//
// Ports:
//   aclk, aresetn        clock, synchronous active-low reset
//   s_axis_*             ingress AXI4-Stream (tready is 1 whenever out of reset)
//   m_axis_*             egress AXI4-Stream, first-word-fall-through register
//   pkt_drop             one-cycle pulse per dropped packet
//   stat_pkt_out, stat_pkt_drop, stat_byte_out
//                        wrapping statistics counters, present only when the
//                        macro NF10_OQ_EGRESS_STATS_EN is defined
// ---------------------------------------------------------------------------
module nf10_oq_port_egress_fifo #(
    parameter int C_AXIS_DATA_WIDTH  = 256,
    parameter int C_AXIS_TUSER_WIDTH = 128,
    parameter int C_DEPTH            = 64,
    parameter int C_CNT_WIDTH        = 32
) (
    input  logic                            aclk,
    input  logic                            aresetn,
    input  logic [C_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
    input  logic [C_AXIS_DATA_WIDTH/8-1:0]  s_axis_tstrb,
    input  logic [C_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
    input  logic                            s_axis_tvalid,
    output logic                            s_axis_tready,
    input  logic                            s_axis_tlast,
    output logic [C_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
    output logic [C_AXIS_DATA_WIDTH/8-1:0]  m_axis_tstrb,
    output logic [C_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
    output logic                            m_axis_tvalid,
    input  logic                            m_axis_tready,
    output logic                            m_axis_tlast,
    output logic                            pkt_drop
`ifdef NF10_OQ_EGRESS_STATS_EN
    ,
    output logic [C_CNT_WIDTH-1:0]          stat_pkt_out,
    output logic [C_CNT_WIDTH-1:0]          stat_pkt_drop,
    output logic [C_CNT_WIDTH-1:0]          stat_byte_out
`endif
);

    localparam int STRB_W = C_AXIS_DATA_WIDTH / 8;
    localparam int WORD_W = 1 + C_AXIS_TUSER_WIDTH + STRB_W + C_AXIS_DATA_WIDTH;
    localparam int AW     = $clog2(C_DEPTH);
    localparam int PW     = AW + 1;
    localparam logic [PW-1:0] DEPTH_P = PW'(C_DEPTH);

    // Elaboration-time guard on the configuration.
    if (C_DEPTH < 4 || (C_DEPTH & (C_DEPTH - 1)) != 0 || C_CNT_WIDTH < 1) begin : g_param_check
        $error("nf10_oq_port_egress_fifo: C_DEPTH must be a power of 2 >= 4 and C_CNT_WIDTH >= 1");
    end

    typedef enum logic {ST_ACCEPT, ST_DROP} state_t;

    // Storage word layout: {tlast, tuser, tstrb, tdata}
    logic [WORD_W-1:0] mem [C_DEPTH];
    logic [WORD_W-1:0] out_word_reg;

    state_t          state_reg, state_next;
    logic [PW-1:0]   wr_ptr_reg, wr_ptr_next;
    logic [PW-1:0]   commit_ptr_reg, commit_ptr_next;
    logic [PW-1:0]   rd_ptr_reg;
    logic [PW-1:0]   pkt_cnt_reg;
    logic            out_valid_reg;
    logic            s_ready_reg;
    logic            pkt_drop_reg, drop_next;
    logic            mem_we, commit;
    logic            in_beat, fifo_full;
    logic            handshake, pop_pkt, load;

    assign in_beat   = s_axis_tvalid & s_ready_reg;
    // Full is judged against rd_ptr_reg, so a slot freed by a read this
    // cycle is only visible to the writer at the next edge.
    assign fifo_full = (wr_ptr_reg - rd_ptr_reg) == DEPTH_P;

    // Ingress / drop state machine
    always_comb begin
        state_next      = state_reg;
        wr_ptr_next     = wr_ptr_reg;
        commit_ptr_next = commit_ptr_reg;
        mem_we          = 1'b0;
        commit          = 1'b0;
        drop_next       = 1'b0;
        if (in_beat) begin
            case (state_reg)
                ST_ACCEPT: begin
                    if (fifo_full) begin
                        // Discard the partial packet already written.
                        wr_ptr_next = commit_ptr_reg;
                        if (s_axis_tlast) begin
                            drop_next = 1'b1;
                        end else begin
                            state_next = ST_DROP;
                        end
                    end else begin
                        mem_we      = 1'b1;
                        wr_ptr_next = wr_ptr_reg + PW'(1);
                        if (s_axis_tlast) begin
                            commit_ptr_next = wr_ptr_reg + PW'(1);
                            commit          = 1'b1;
                        end
                    end
                end
                ST_DROP: begin
                    if (s_axis_tlast) begin
                        drop_next  = 1'b1;
                        state_next = ST_ACCEPT;
                    end
                end
                default: state_next = ST_ACCEPT;
            endcase
        end
    end

    // Egress: prefetch the next committed beat whenever the output register
    // is empty or being consumed this cycle.
    assign handshake = m_axis_tvalid & m_axis_tready;
    assign pop_pkt   = handshake & out_word_reg[WORD_W-1];
    assign load      = (~out_valid_reg | handshake) & (commit_ptr_reg != rd_ptr_reg);

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_reg      <= ST_ACCEPT;
            wr_ptr_reg     <= '0;
            commit_ptr_reg <= '0;
            rd_ptr_reg     <= '0;
            pkt_cnt_reg    <= '0;
            out_valid_reg  <= 1'b0;
            s_ready_reg    <= 1'b0;
            pkt_drop_reg   <= 1'b0;
        end else begin
            state_reg      <= state_next;
            wr_ptr_reg     <= wr_ptr_next;
            commit_ptr_reg <= commit_ptr_next;
            s_ready_reg    <= 1'b1;
            pkt_drop_reg   <= drop_next;
            pkt_cnt_reg    <= pkt_cnt_reg + PW'(commit) - PW'(pop_pkt);
            if (load) begin
                rd_ptr_reg    <= rd_ptr_reg + PW'(1);
                out_valid_reg <= 1'b1;
            end else if (handshake) begin
                out_valid_reg <= 1'b0;
            end
        end
    end

    // Block RAM: write port from ingress, registered read into the output
    // register. A read never targets the slot being written because writes
    // are blocked while full.
    always_ff @(posedge aclk) begin
        if (mem_we) begin
            mem[wr_ptr_reg[AW-1:0]] <= {s_axis_tlast, s_axis_tuser, s_axis_tstrb, s_axis_tdata};
        end
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            out_word_reg <= '0;
        end else if (load) begin
            out_word_reg <= mem[rd_ptr_reg[AW-1:0]];
        end
    end

    assign s_axis_tready = s_ready_reg;
    assign m_axis_tvalid = out_valid_reg & (pkt_cnt_reg != '0);
    assign {m_axis_tlast, m_axis_tuser, m_axis_tstrb, m_axis_tdata} = out_word_reg;
    assign pkt_drop      = pkt_drop_reg;

`ifdef NF10_OQ_EGRESS_STATS_EN
    // Popcount of the egress strobes as a prefix-sum chain.
    logic [C_CNT_WIDTH-1:0] strb_sum [STRB_W+1];
    logic [C_CNT_WIDTH-1:0] stat_pkt_out_reg, stat_pkt_drop_reg, stat_byte_out_reg;

    assign strb_sum[0] = '0;
    for (genvar gi = 0; gi < STRB_W; gi++) begin : g_popcount
        assign strb_sum[gi+1] = strb_sum[gi] + C_CNT_WIDTH'(m_axis_tstrb[gi]);
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            stat_pkt_out_reg  <= '0;
            stat_pkt_drop_reg <= '0;
            stat_byte_out_reg <= '0;
        end else begin
            if (pop_pkt) begin
                stat_pkt_out_reg <= stat_pkt_out_reg + C_CNT_WIDTH'(1);
            end
            if (pkt_drop_reg) begin
                stat_pkt_drop_reg <= stat_pkt_drop_reg + C_CNT_WIDTH'(1);
            end
            if (handshake) begin
                stat_byte_out_reg <= stat_byte_out_reg + strb_sum[STRB_W];
            end
        end
    end

    assign stat_pkt_out  = stat_pkt_out_reg;
    assign stat_pkt_drop = stat_pkt_drop_reg;
    assign stat_byte_out = stat_byte_out_reg;
`endif

endmodule
